// File: rtl/mem_write_buffer.sv
// Posted-write buffer between the datapath memory port and memorySystem.
// Writes are queued and drained one per clock; reads forward from the youngest matching entry.
package mem_write_buffer_pkg;
  typedef enum logic { MEM_WR = 1'b0, NO_WR = 1'b1 } wr_cond_code_t;
  typedef enum logic { MEM_RD = 1'b0, NO_RD = 1'b1 } rd_cond_code_t;
endpackage

module mem_write_buffer
  import mem_write_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int DW    = 16
) (
  input  logic                    clock,
  input  logic                    reset_L,
  input  wr_cond_code_t           cpu_we,
  input  rd_cond_code_t           cpu_re,
  input  logic [AW-1:0]           cpu_addr,
  input  logic [DW-1:0]           cpu_wdata,
  input  logic                    cpu_fence,
  output logic [DW-1:0]           cpu_rdata,
  output logic                    cpu_stall,
  output wr_cond_code_t           mem_we_L,
  output rd_cond_code_t           mem_re_L,
  output logic [AW-1:0]           mem_addr,
  inout  wire  [DW-1:0]           mem_data,
  output logic [$clog2(DEPTH):0]  wb_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;

  logic          hit;
  logic [DW-1:0] fwd_data;
  logic          wr_req, rd_req, read_act, bus_hold, bus_read;
  logic          drain, fence_hold, full_block, enq;

  // Walk entries oldest to youngest so the last match wins.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < count) && (addr_q[head + PW'(k)] == cpu_addr)) begin
        hit      = 1'b1;
        fwd_data = data_q[head + PW'(k)];
      end
    end
  end

  // Handshake: cpu_stall = 1 means the request is not accepted this cycle and the
  // datapath holds every input; cpu_stall = 0 with cpu_we = MEM_WR means the write is
  // queued at the next posedge. A read request that misses the buffer reserves the bus
  // for that cycle (even alongside a write), so no drain happens then.
  always_comb begin
    wr_req     = reset_L && (cpu_we == MEM_WR);
    rd_req     = reset_L && (cpu_re == MEM_RD);
    read_act   = rd_req && (cpu_we == NO_WR);
    bus_hold   = rd_req && !hit;
    bus_read   = read_act && !hit;
    drain      = reset_L && (count != '0) && !bus_hold;
    fence_hold = reset_L && cpu_fence && (count != '0);
    full_block = (count == CW'(DEPTH)) && !drain;
    enq        = wr_req && !full_block && !fence_hold;
  end

  assign cpu_stall = fence_hold || (wr_req && full_block);
  assign mem_we_L  = drain ? MEM_WR : NO_WR;
  assign mem_re_L  = bus_read ? MEM_RD : NO_RD;
  assign mem_addr  = drain ? addr_q[head] : (bus_read ? cpu_addr : '0);
  assign mem_data  = drain ? data_q[head] : 'z;
  assign cpu_rdata = !read_act ? '0 : (hit ? fwd_data : mem_data);
  assign wb_count  = count;

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq)   tail <= tail + PW'(1);
      if (drain) head <= head + PW'(1);
      case ({enq, drain})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (enq) begin
      addr_q[tail] <= cpu_addr;
      data_q[tail] <= cpu_wdata;
    end
  end
endmodule

// File: tb/tb_mem_write_buffer.sv
// Bench for mem_write_buffer: a queue-based model checked every cycle, plus directed
// scenarios with literal expectations.
module tb_mem_write_buffer;
  import mem_write_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic          clock   = 1'b0;
  logic          reset_L = 1'b0;
  wr_cond_code_t cpu_we;
  rd_cond_code_t cpu_re;
  logic [15:0]   cpu_addr, cpu_wdata;
  logic          cpu_fence;
  logic [15:0]   cpu_rdata;
  logic          cpu_stall;
  wr_cond_code_t mem_we_L;
  rd_cond_code_t mem_re_L;
  logic [15:0]   mem_addr;
  wire  [15:0]   mem_data;
  logic [2:0]    wb_count;

  int checks = 0;
  int errors = 0;

  // Model state: program-ordered {addr, data} entries and the memory image they produce.
  logic [31:0] exp_q[$];
  logic [15:0] exp_mem [512];

  // Memory environment on the shared bus.
  logic [15:0] env_mem [512];
  logic [15:0] rd_val;
  logic        lat_we = 1'b0;
  logic [15:0] lat_addr, lat_data;

  typedef struct packed {
    logic        stall;
    logic [15:0] rdata;
    logic        we_l;
    logic        re_l;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        drain;
    logic        enq;
  } exp_t;

  exp_t cmp_e, upd_e;

  always #5 clock = ~clock;

  mem_write_buffer #(.DEPTH(DEPTH), .AW(16), .DW(16)) dut (
    .clock     (clock),
    .reset_L   (reset_L),
    .cpu_we    (cpu_we),
    .cpu_re    (cpu_re),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_fence (cpu_fence),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .mem_we_L  (mem_we_L),
    .mem_re_L  (mem_re_L),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .wb_count  (wb_count)
  );

  always_comb rd_val = env_mem[mem_addr[8:0]];
  assign mem_data = (mem_re_L == MEM_RD) ? rd_val : 16'hzzzz;

  always @(negedge clock) begin
    lat_we   = (mem_we_L == MEM_WR);
    lat_addr = mem_addr;
    lat_data = mem_data;
  end

  always @(posedge clock) begin
    if (reset_L && lat_we) env_mem[lat_addr[8:0]] = lat_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Outputs implied by the current request and the queued writes.
  function automatic exp_t model_eval();
    exp_t        e;
    int          n;
    logic        read_act, hit, miss_req;
    logic [15:0] fwd;
    n        = exp_q.size();
    e        = '0;
    read_act = (cpu_re == MEM_RD) && (cpu_we == NO_WR);
    hit      = 1'b0;
    fwd      = 16'h0;
    foreach (exp_q[i]) begin
      if (exp_q[i][31:16] == cpu_addr) begin
        hit = 1'b1;
        fwd = exp_q[i][15:0];
      end
    end
    miss_req = (cpu_re == MEM_RD) && !hit;
    e.drain  = (n > 0) && !miss_req;
    e.stall  = (cpu_fence && n > 0) || ((cpu_we == MEM_WR) && n == DEPTH && !e.drain);
    e.enq    = (cpu_we == MEM_WR) && !e.stall;
    e.we_l   = !e.drain;
    e.re_l   = !(read_act && !hit);
    if (!read_act)  e.rdata = 16'h0;
    else if (hit)   e.rdata = fwd;
    else            e.rdata = exp_mem[cpu_addr[8:0]];
    if (e.drain) begin
      e.addr  = exp_q[0][31:16];
      e.wdata = exp_q[0][15:0];
    end else if (read_act && !hit) begin
      e.addr = cpu_addr;
    end
    return e;
  endfunction

  always @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      exp_q.delete();
    end else begin
      upd_e = model_eval();
      if (upd_e.drain) begin
        exp_mem[exp_q[0][24:16]] = exp_q[0][15:0];
        void'(exp_q.pop_front());
      end
      if (upd_e.enq) exp_q.push_back({cpu_addr, cpu_wdata});
    end
  end

  always @(negedge clock) begin
    if (!reset_L) begin
      chk("m_rst_stall", 32'(cpu_stall), 32'd0);
      chk("m_rst_rdata", 32'(cpu_rdata), 32'd0);
      chk("m_rst_we", 32'(mem_we_L), 32'(NO_WR));
      chk("m_rst_re", 32'(mem_re_L), 32'(NO_RD));
      chk("m_rst_addr", 32'(mem_addr), 32'd0);
      chk("m_rst_count", 32'(wb_count), 32'd0);
    end else begin
      cmp_e = model_eval();
      chk("m_stall", 32'(cpu_stall), 32'(cmp_e.stall));
      chk("m_rdata", 32'(cpu_rdata), 32'(cmp_e.rdata));
      chk("m_we", 32'(mem_we_L), 32'(cmp_e.we_l));
      chk("m_re", 32'(mem_re_L), 32'(cmp_e.re_l));
      chk("m_addr", 32'(mem_addr), 32'(cmp_e.addr));
      chk("m_count", 32'(wb_count), 32'(exp_q.size()));
      if (cmp_e.drain) chk("m_wdata", 32'(mem_data), 32'(cmp_e.wdata));
    end
  end

  task automatic drive(input wr_cond_code_t we, input rd_cond_code_t re,
                       input logic [15:0] a, input logic [15:0] d, input logic f);
    cpu_we    = we;
    cpu_re    = re;
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_fence = f;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    drive(NO_WR, NO_RD, 16'h0000, 16'h0000, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      env_mem[i] = 16'h5000 + 16'(i);
      exp_mem[i] = 16'h5000 + 16'(i);
    end
    drive(NO_WR, MEM_RD, 16'h0040, 16'h0000, 1'b0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst_we", 32'(mem_we_L), 32'(NO_WR));
    chk("rst_re", 32'(mem_re_L), 32'(NO_RD));
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_count", 32'(wb_count), 32'd0);
    idle();
    repeat (2) @(posedge clock);
    #1 reset_L = 1'b1;
    tick();

    // Plain miss read from an empty buffer.
    drive(NO_WR, MEM_RD, 16'h0000, 16'h0000, 1'b0);
    chk("miss_rdata", 32'(cpu_rdata), 32'h5000);
    chk("miss_re", 32'(mem_re_L), 32'(MEM_RD));
    tick();

    // Single write then drain.
    drive(MEM_WR, NO_RD, 16'h0100, 16'hBEEF, 1'b0);
    chk("t1_stall", 32'(cpu_stall), 32'd0);
    tick();
    chk("t1_count1", 32'(wb_count), 32'd1);
    idle();
    chk("t1_drain_we", 32'(mem_we_L), 32'(MEM_WR));
    chk("t1_drain_addr", 32'(mem_addr), 32'h0100);
    chk("t1_drain_data", 32'(mem_data), 32'hBEEF);
    tick();
    chk("t1_count0", 32'(wb_count), 32'd0);
    chk("t1_mem", 32'(env_mem[9'h100]), 32'hBEEF);

    // Fill with writes while missing reads hold the bus.
    for (int i = 0; i < 4; i++) begin
      drive(MEM_WR, MEM_RD, 16'h0100 + 16'(i), 16'hA000 + 16'(i), 1'b0);
      chk("t2_accept", 32'(cpu_stall), 32'd0);
      tick();
    end
    chk("t2_full", 32'(wb_count), 32'd4);
    drive(MEM_WR, MEM_RD, 16'h0104, 16'hA004, 1'b0);
    chk("t2_stall5", 32'(cpu_stall), 32'd1);
    chk("t2_no_re", 32'(mem_re_L), 32'(NO_RD));
    chk("t2_rdata0", 32'(cpu_rdata), 32'd0);
    tick();
    chk("t2_hold_count", 32'(wb_count), 32'd4);
    chk("t2_stall5b", 32'(cpu_stall), 32'd1);
    tick();
    drive(MEM_WR, NO_RD, 16'h0104, 16'hA004, 1'b0);
    chk("t2_unstall", 32'(cpu_stall), 32'd0);
    chk("t2_first_out", 32'(mem_addr), 32'h0100);
    tick();
    chk("t4_count_full", 32'(wb_count), 32'd4);

    // Full buffer: write and drain together, pointers wrap.
    for (int i = 5; i < 8; i++) begin
      drive(MEM_WR, NO_RD, 16'h0100 + 16'(i), 16'hA000 + 16'(i), 1'b0);
      chk("t4_stall", 32'(cpu_stall), 32'd0);
      chk("t4_order", 32'(mem_addr), 32'h0100 + 32'(i - 4));
      tick();
      chk("t4_count", 32'(wb_count), 32'd4);
    end
    for (int i = 4; i < 8; i++) begin
      idle();
      chk("t4_drain_order", 32'(mem_addr), 32'h0100 + 32'(i));
      tick();
    end
    chk("t4_empty", 32'(wb_count), 32'd0);
    for (int i = 0; i < 8; i++) chk("t4_mem", 32'(env_mem[9'h100 + 9'(i)]), 32'hA000 + 32'(i));

    // Store forwarding from the youngest of two same-address entries.
    drive(MEM_WR, MEM_RD, 16'h0120, 16'h3333, 1'b0);
    tick();
    drive(MEM_WR, MEM_RD, 16'h0110, 16'h1111, 1'b0);
    chk("t3_hold", 32'(mem_we_L), 32'(NO_WR));
    tick();
    chk("t3_count2", 32'(wb_count), 32'd2);
    drive(MEM_WR, MEM_RD, 16'h0110, 16'h2222, 1'b0);
    chk("t3_hit_drain", 32'(mem_addr), 32'h0120);
    tick();
    drive(NO_WR, MEM_RD, 16'h0110, 16'h0000, 1'b0);
    chk("t3_fwd", 32'(cpu_rdata), 32'h2222);
    chk("t3_no_re", 32'(mem_re_L), 32'(NO_RD));
    chk("t3_old_out", 32'(mem_data), 32'h1111);
    tick();
    idle();
    tick();
    chk("t3_empty", 32'(wb_count), 32'd0);
    chk("t3_mem", 32'(env_mem[9'h110]), 32'h2222);
    chk("t3_mem_y", 32'(env_mem[9'h120]), 32'h3333);

    // Fence with three queued entries.
    for (int i = 0; i < 3; i++) begin
      drive(MEM_WR, MEM_RD, 16'h0130 + 16'(i), 16'hC000 + 16'(i), 1'b0);
      tick();
    end
    chk("t5_count3", 32'(wb_count), 32'd3);
    for (int k = 0; k < 4; k++) begin
      drive(NO_WR, NO_RD, 16'h0000, 16'h0000, 1'b1);
      chk("t5_fence", 32'(cpu_stall), (k < 3) ? 32'd1 : 32'd0);
      tick();
    end
    chk("t5_empty", 32'(wb_count), 32'd0);

    // Reset while draining.
    drive(MEM_WR, MEM_RD, 16'h0140, 16'h7777, 1'b0);
    tick();
    drive(MEM_WR, MEM_RD, 16'h0141, 16'h8888, 1'b0);
    tick();
    chk("t6_count2", 32'(wb_count), 32'd2);
    idle();
    chk("t6_draining", 32'(mem_we_L), 32'(MEM_WR));
    reset_L = 1'b0;
    #1;
    chk("t6_we", 32'(mem_we_L), 32'(NO_WR));
    chk("t6_addr", 32'(mem_addr), 32'd0);
    chk("t6_count", 32'(wb_count), 32'd0);
    chk("t6_stall", 32'(cpu_stall), 32'd0);
    drive(MEM_WR, NO_RD, 16'h0150, 16'h9999, 1'b0);
    chk("t6_wr_in_rst", 32'(cpu_stall), 32'd0);
    tick();
    idle();
    tick();
    reset_L = 1'b1;
    tick();
    tick();
    chk("t6_count_after", 32'(wb_count), 32'd0);
    chk("t6_mem0", 32'(env_mem[9'h140]), 32'h5140);
    chk("t6_mem1", 32'(env_mem[9'h141]), 32'h5141);
    chk("t6_mem2", 32'(env_mem[9'h150]), 32'h5150);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
